// File: rtl/bi_mem_arb_pkg.sv
// Shared types and helpers for the arbitrated single-port memory.
package bi_mem_arb_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  // Widest request vector rr_pick can handle.
  localparam int unsigned RR_MAX = 32;

  // One-hot grant for the first set bit of req, scanning ptr, ptr+1, ...
  // modulo n (n = number of live channels, n <= RR_MAX, ptr < n).
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                input int unsigned ptr,
                                                input int unsigned n);
    logic [RR_MAX-1:0] grant;
    logic              found;
    int unsigned       idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < RR_MAX; k++) begin
      if (k < n && !found) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/bi_mem_arb_rr.sv
// Round-robin arbiter: one-hot grant from the registered pointer; the pointer
// moves past the winner whenever a grant is taken.
module bi_mem_arb_rr
  import bi_mem_arb_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] req,
  input  logic                advance,
  output logic [CHANNELS-1:0] grant,
  output logic [CW-1:0]       ptr
);

  logic [CW-1:0] gidx;
  logic [CW-1:0] ptr_next;

  assign grant = CHANNELS'(rr_pick(RR_MAX'(req), 32'(ptr), CHANNELS));

  // Encode the winner and compute the pointer position just past it.
  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (grant[i]) gidx = CW'(i);
    end
    if (gidx == CW'(CHANNELS - 1)) ptr_next = '0;
    else                           ptr_next = gidx + 1'b1;
  end

  // Pointer register; unchanged on idle cycles.
  always_ff @(posedge clk) begin
    if (rst)          ptr <= '0;
    else if (advance) ptr <= ptr_next;
  end

endmodule

// File: rtl/bi_mem_arb.sv
// Single-port memory shared by CHANNELS BiMem requesters via round-robin.
// Optional power-up clear of the array is enabled by BI_MEM_ARB_CLEAR_EN.
module bi_mem_arb
  import bi_mem_arb_pkg::*;
#(
  parameter string       PROFILE  = "default",
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned HEIGHT   = 16,
  parameter int unsigned CHANNELS = 2,
  localparam int unsigned AW      = $clog2(HEIGHT),
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [CHANNELS-1:0]           enable_i,
  input  logic [CHANNELS-1:0]           isWrite_i,
  input  logic [CHANNELS-1:0][AW-1:0]   addr_i,
  input  logic [CHANNELS-1:0][WIDTH-1:0] writeData_i,
  output logic [CHANNELS-1:0][WIDTH-1:0] readData_o,
  output logic [CHANNELS-1:0]           hold_o
);

  logic [WIDTH-1:0]    mem [HEIGHT];
  logic                active;
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] grant;
  logic [CW-1:0]       ptr;
  logic                accept;
  logic                sel_we;
  logic [AW-1:0]       sel_addr;
  logic [WIDTH-1:0]    sel_wdata;
  logic                in_range;
  logic [WIDTH-1:0]    rd_word;

`ifdef BI_MEM_ARB_CLEAR_EN
  state_t        state_q, state_d;
  logic [AW-1:0] clr_q, clr_d;
  logic          clearing;

  // Clear-sequencer state register; reset restarts the sweep at address 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  // Sweep every address once, then hand the array to the requesters.
  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    clearing = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clearing = 1'b1;
        clr_d    = clr_q + 1'b1;
        if (clr_q == AW'(HEIGHT - 1)) begin
          state_d = ST_RUN;
          clr_d   = '0;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  assign active = (state_q == ST_RUN) && !rst_i;
`else
  assign active = !rst_i;
`endif

  // Gating the requests (not the grant) keeps hold_o = enable_i while blocked.
  assign req    = enable_i & {CHANNELS{active}};
  assign accept = |grant;
  assign hold_o = enable_i & ~grant;

  bi_mem_arb_rr #(
    .CHANNELS (CHANNELS),
    .CW       (CW)
  ) u_rr (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (req),
    .advance (accept),
    .grant   (grant),
    .ptr     (ptr)
  );

  // Steer the granted channel's command onto the single memory port.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (grant[c]) begin
        sel_we    = isWrite_i[c];
        sel_addr  = addr_i[c];
        sel_wdata = writeData_i[c];
      end
    end
  end

  assign in_range = 32'(sel_addr) < HEIGHT;
  assign rd_word  = in_range ? mem[sel_addr] : '0;

  // Storage array: clear sweep or accepted in-range write.
  always_ff @(posedge clk_i) begin
`ifdef BI_MEM_ARB_CLEAR_EN
    if (clearing && !rst_i) mem[clr_q] <= '0;
    else
`endif
    if (accept && sel_we && in_range) mem[sel_addr] <= sel_wdata;
  end

  // Per-channel read registers load only on that channel's accepted read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      readData_o <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (grant[c] && !sel_we) readData_o[c] <= rd_word;
      end
    end
  end

endmodule
